barrel_shift_pipe: RTL

BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

---
 rtl/shifter_pkg.sv | 11 +
 rtl/shift_stage.sv | 31 +++
 rtl/barrel_shift_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared shift-operation encodings, used by the barrel shifter and the ALU decoder.
package shifter_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } shift_mode_t;

endpackage

// File: rtl/shift_stage.sv
// One combinational level of the barrel shifter: shifts or rotates by DIST
// bit positions when en is set, otherwise passes the data through unchanged.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  shift_mode_t      mode,
    input  logic             en,
    output logic [WIDTH-1:0] data_out
);

    // Select the shifted form for the requested operation; pure wiring, no adders.
    // For SRA the current MSB is always the operand's original sign bit, because
    // earlier levels only ever replicate it, so it serves as the fill value here.
    always_comb begin
        data_out = data_in;
        if (en) begin
            case (mode)
                MODE_SLL: data_out = {data_in[WIDTH-1-DIST:0], {DIST{1'b0}}};
                MODE_SRL: data_out = {{DIST{1'b0}}, data_in[WIDTH-1:DIST]};
                MODE_SRA: data_out = {{DIST{data_in[WIDTH-1]}}, data_in[WIDTH-1:DIST]};
                MODE_ROR: data_out = {data_in[DIST-1:0], data_in[WIDTH-1:DIST]};
                default:  data_out = data_in;
            endcase
        end
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: SHW registered levels, level k shifting by 2^k.
// Valid/ready handshake on both sides; the whole pipe advances or holds as one.
module barrel_shift_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Stage register k holds the result of level k. Mode and the remaining
    // amount bits are only carried while a later level still needs them, so
    // the last stage register holds just valid and data. amt_p[k] is the
    // original amount shifted right by k+1: bit 0 drives level k+1.
    logic              vld_p   [SHW];
    logic [WIDTH-1:0]  data_p  [SHW];
    shift_mode_t       mode_p  [SHW-1];
    logic [SHW-1:0]    amt_p   [SHW-1];

    logic [WIDTH-1:0]  st_in   [SHW];
    shift_mode_t       st_mode [SHW];
    logic              st_en   [SHW];
    logic [WIDTH-1:0]  st_out  [SHW];

    logic              adv;

    // A bubble or a consumed result at the output lets every stage move.
    assign adv       = out_ready || !vld_p[SHW-1];
    assign in_ready  = adv;
    assign out_valid = vld_p[SHW-1];
    assign out_data  = data_p[SHW-1];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign st_in[k]   = in_data;
            assign st_mode[k] = shift_mode_t'(in_mode);
            assign st_en[k]   = in_amt[0];
        end else begin : g_next
            assign st_in[k]   = data_p[k-1];
            assign st_mode[k] = mode_p[k-1];
            assign st_en[k]   = amt_p[k-1][0];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .data_in  (st_in[k]),
            .mode     (st_mode[k]),
            .en       (st_en[k]),
            .data_out (st_out[k])
        );
    end

    // Pipeline registers: cleared by reset, loaded together on every advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SHW; k++) begin
                vld_p[k]  <= 1'b0;
                data_p[k] <= '0;
            end
            for (int k = 0; k < SHW-1; k++) begin
                mode_p[k] <= MODE_SLL;
                amt_p[k]  <= '0;
            end
        end else if (adv) begin
            vld_p[0]  <= in_valid;
            data_p[0] <= st_out[0];
            mode_p[0] <= st_mode[0];
            amt_p[0]  <= {1'b0, in_amt[SHW-1:1]};
            for (int k = 1; k < SHW; k++) begin
                vld_p[k]  <= vld_p[k-1];
                data_p[k] <= st_out[k];
            end
            for (int k = 1; k < SHW-1; k++) begin
                mode_p[k] <= mode_p[k-1];
                amt_p[k]  <= {1'b0, amt_p[k-1][SHW-1:1]};
            end
        end
    end

endmodule
